// File: rtl/melody_seq.sv
// Note-table melody sequencer: plays entries 0..last_idx, each for a programmed
// number of ticks, with optional silent gaps and looping; drives a tone clock generator.
module melody_seq #(
    parameter int DEPTH     = 32,
    parameter int PITCH_W   = 5,
    parameter int DUR_W     = 13,
    parameter int TICK_DIV  = 125,
    parameter int GAP_TICKS = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PITCH_W-1:0] wr_pitch,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic [AW-1:0]      last_idx,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    output logic               busy,
    output logic               done,
    output logic               note_start,
    output logic [PITCH_W-1:0] pitch_out,
    output logic               note_valid,
    output logic [AW-1:0]      cur_idx
);

    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [PITCH_W+DUR_W-1:0] r_mem [DEPTH];

    logic [1:0]       r_state;
    logic [PRE_W-1:0] r_pre;
    logic [DUR_W-1:0] r_dur;
    logic [DUR_W-1:0] r_dur_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [AW-1:0]    r_last_idx;

    logic               w_tick;
    logic [DUR_W-1:0]   w_dur_last;
    logic               w_note_end;
    logic               w_gap_end;
    logic               w_at_last;
    logic               w_advance;
    logic               w_enter_gap;
    logic               w_load;
    logic               w_finish;
    logic [AW-1:0]      w_load_idx;
    logic [PITCH_W-1:0] w_entry_pitch;
    logic [DUR_W-1:0]   w_entry_dur;

    // Note table write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_pitch, wr_dur};
        end
    end

    // Tick, note-end and advance decisions; a duration of 0 behaves as 1
    always_comb begin
        w_tick      = (r_pre == PRE_W'(TICK_DIV - 1));
        w_dur_last  = (r_dur == '0) ? '0 : (r_dur - DUR_W'(1));
        w_note_end  = w_tick && (r_dur_cnt == w_dur_last);
        w_gap_end   = w_tick && (r_gap_cnt == GAP_W'(GAP_LAST));
        w_at_last   = (cur_idx == r_last_idx);
        w_advance   = ((r_state == S_PLAY) && w_note_end && (GAP_TICKS == 0)) ||
                      ((r_state == S_GAP) && w_gap_end);
        w_enter_gap = !stop && (r_state == S_PLAY) && w_note_end && (GAP_TICKS > 0);
        w_load      = !stop && (((r_state == S_IDLE) && start) ||
                                (w_advance && (!w_at_last || loop_en)));
        w_finish    = !stop && w_advance && w_at_last && !loop_en;
        if ((r_state == S_IDLE) || w_at_last) begin
            w_load_idx = '0;
        end else begin
            w_load_idx = cur_idx + AW'(1);
        end
        {w_entry_pitch, w_entry_dur} = r_mem[w_load_idx];
    end

    // Sequencer state, counters and registered outputs; stop overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pre      <= '0;
            r_dur      <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_last_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            note_start <= 1'b0;
            note_valid <= 1'b0;
            pitch_out  <= '0;
            cur_idx    <= '0;
        end else begin
            done       <= w_finish;
            note_start <= w_load;
            if (stop || w_finish) begin
                r_state    <= S_IDLE;
                busy       <= 1'b0;
                note_valid <= 1'b0;
                r_pre      <= '0;
                r_dur_cnt  <= '0;
                r_gap_cnt  <= '0;
            end else if (w_load) begin
                r_state    <= S_PLAY;
                busy       <= 1'b1;
                cur_idx    <= w_load_idx;
                pitch_out  <= w_entry_pitch;
                r_dur      <= w_entry_dur;
                note_valid <= (w_entry_pitch != '0);
                r_pre      <= '0;
                r_dur_cnt  <= '0;
                r_gap_cnt  <= '0;
                if (r_state == S_IDLE) begin
                    r_last_idx <= last_idx;
                end
            end else if (w_enter_gap) begin
                r_state    <= S_GAP;
                note_valid <= 1'b0;
                r_pre      <= '0;
                r_gap_cnt  <= '0;
            end else if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_pre <= '0;
                    if (r_state == S_PLAY) begin
                        r_dur_cnt <= r_dur_cnt + DUR_W'(1);
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end else begin
                    r_pre <= r_pre + PRE_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 SHALL provide parameter DEPTH, default 32: note-table entries (power of two, >=2); AW = clog2(DEPTH).
REQ-002 SHALL provide parameter PITCH_W, default 5: pitch code width; code 0 = rest.
REQ-003 SHALL provide parameter DUR_W, default 13: duration width, in ticks.
REQ-004 SHALL provide parameter TICK_DIV, default 125: clk cycles per duration tick (>=2).
REQ-005 SHALL provide parameter GAP_TICKS, default 0: silent ticks inserted after every note.
REQ-006 SHALL provide clk  in  1  single clock, all logic on rising edge.
REQ-007 SHALL provide reset  in  1  asynchronous, active-high.
REQ-008 SHALL provide wr_en  in  1  table write strobe.
REQ-009 SHALL provide wr_addr  in  AW  table write address.
REQ-010 SHALL provide wr_pitch  in  PITCH_W  pitch code to write.
REQ-011 SHALL provide wr_dur  in  DUR_W  duration to write.
REQ-012 SHALL provide last_idx  in  AW  index of final note.
REQ-013 SHALL provide start / stop / loop_en  in  1 each  control inputs.
REQ-014 SHALL provide busy  out  1  high in PLAY or GAP.
REQ-015 SHALL provide done  out  1  one-cycle pulse on non-looped completion.
REQ-016 SHALL provide note_start  out  1  one-cycle pulse on every note load (resets downstream tone clkgen).
REQ-017 SHALL provide pitch_out  out  PITCH_W  current pitch code (maxval for tone clkgen).
REQ-018 SHALL provide note_valid  out  1  high when pitch_out is audible (PLAY and pitch != 0).
REQ-019 SHALL provide cur_idx  out  AW  index of current note.

Function
REQ-020 SHALL implement FSM states IDLE, PLAY, GAP; IDLE after reset.
REQ-021 SHALL write {wr_pitch, wr_dur} to entry wr_addr on any cycle with wr_en, in any state; table contents are not reset.
REQ-022 SHALL, in IDLE with start=1 and stop=0, capture last_idx, load entry 0 and enter PLAY the next cycle with note_start=1, cur_idx=0, prescaler and duration counter cleared.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL generate a tick every TICK_DIV cycles in PLAY/GAP; the first tick of a note occurs TICK_DIV cycles after note_start.
REQ-025 SHALL end a note on the tick where the duration count reaches dur-1; a dur of 0 is treated as 1.
REQ-026 SHALL, at note end, enter GAP for GAP_TICKS ticks if GAP_TICKS>0, else advance immediately; in GAP, pitch_out holds and note_valid=0.
REQ-027 SHALL advance by loading entry cur_idx+1 with a note_start pulse; if cur_idx==captured last_idx, it SHALL load entry 0 when loop_en=1, else go to IDLE with done=1 for one cycle.
REQ-028 SHALL sample loop_en only at the advance decision.
REQ-029 SHALL latch pitch and duration at note load; a write to the playing entry takes effect only at its next load.
REQ-030 SHALL, on stop=1 in any state, enter IDLE the next cycle with no done pulse; stop wins over simultaneous start.
REQ-031 SHALL hold pitch_out and cur_idx in IDLE; note_valid=0 and busy=0 in IDLE.
REQ-032 SHALL keep total latency from start to first audible pitch_out at 1 cycle.

Reset
REQ-033 SHALL, on reset assertion, immediately force state IDLE, busy=0, done=0, note_start=0, note_valid=0, pitch_out=0, cur_idx=0, and clear all counters.
REQ-034 SHALL abort playback when reset is asserted mid-note; operation resumes only on a new start after release.

Verification (TICK_DIV=4, DEPTH=4)
REQ-035 SHALL cover: write {3,2},{5,1},{0,1} at 0..2, last_idx=2, loop_en=0, start -> pitch 3 for 8 cycles, pitch 5 for 4, rest (note_valid=0) for 4, then done pulse; busy=0.
REQ-036 SHALL cover: same table with loop_en=1 -> after entry 2, note_start with cur_idx=0 and pitch 3; no done pulse.
REQ-037 SHALL cover: GAP_TICKS=1 -> 4 cycles with note_valid=0 between each note; note_start pulses spaced 12, 8, 8 cycles.
REQ-038 SHALL cover: stop mid-note, then start and stop on the same cycle -> IDLE next cycle, no done pulse, no restart.
REQ-039 SHALL cover: dur=0 entry -> plays 4 cycles; rewrite of the playing entry -> old value kept until its next load.
REQ-040 SHALL cover: reset asserted mid-note -> all outputs at reset values without a clock edge.
